// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: UART transmitter fed by a DEPTH-entry FIFO, zero-gap frames; parity bit only when SERIAL_TX_PARITY_EN is defined
module serial_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int BIT_CYCLES = 5201,
  parameter int STOP_BITS  = 1,
  parameter int DEPTH      = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                 m_clock,
  input  logic                 p_reset,
  input  logic [DATA_BITS-1:0] datain,
  input  logic                 launch,
  output logic                 ready,
  input  logic                 parity_odd,
  output logic                 TDX,
  output logic                 busy,
  output logic                 complete,
  output logic [LW-1:0]        level
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef SERIAL_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic tdx_q, tdx_d;
  logic bit_end, push, pop;
  assign bit_end  = cnt_q == 16'(BIT_CYCLES - 1);
  assign complete = state_q == STOP && bit_end && idx_q == 4'(STOP_BITS - 1);
  assign push     = launch && ready;
  assign pop      = level_q != '0 && (state_q == IDLE || complete);
  assign ready    = level_q != LW'(DEPTH);
  assign busy     = state_q != IDLE;
  assign level    = level_q;
  assign TDX      = tdx_q;
  assign level_d  = level_q + LW'(push) - LW'(pop);
  assign cnt_d    = (state_q == IDLE || bit_end) ? '0 : cnt_q + 16'd1;
  assign idx_d    = bit_end ? (state_d == state_q ? idx_q + 4'd1 : '0) : idx_q;
  assign sh_d     = pop ? mem[rd_q] : (state_q == DATA && bit_end) ? sh_q >> 1 : sh_q;
`ifdef SERIAL_TX_PARITY_EN
  logic par_q, par_d;
  assign par_d = pop ? (^mem[rd_q]) ^ parity_odd : par_q;
  assign tdx_d = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : state_q == PARITY ? par_q : 1'b1;
  always_ff @(posedge m_clock)
    par_q <= p_reset ? 1'b0 : par_d;
`else
  logic unused_parity;
  assign unused_parity = parity_odd;
  assign tdx_d = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = pop ? START : IDLE;
      START:  state_d = bit_end ? DATA : START;
      DATA:   state_d = (bit_end && idx_q == 4'(DATA_BITS - 1)) ? AFTER_DATA : DATA;
`ifdef SERIAL_TX_PARITY_EN
      PARITY: state_d = bit_end ? STOP : PARITY;
`endif
      STOP:   state_d = complete ? (pop ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge m_clock)
    if (push) mem[wr_q] <= datain;
  always_ff @(posedge m_clock)
    if (p_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      sh_q    <= '0;
      tdx_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      level_q <= level_d;
      sh_q    <= sh_d;
      tdx_q   <= tdx_d;
    end
endmodule
